// File: rtl/fx_bus_master.sv
// fx_bus_master: parses host command bytes into fx bus write/read strobes and returns read data bytes
module fx_bus_master #(
  parameter int TIMEOUT_CYC = 1000000,
  parameter int TO_W        = 20
) (
  input  logic        clk_sys,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_vld,
  output logic        rx_rdy,
  output logic [7:0]  tx_data,
  output logic        tx_vld,
  input  logic        tx_rdy,
  output logic [21:0] fx_waddr,
  output logic        fx_wr,
  output logic [7:0]  fx_data,
  output logic        fx_rd,
  output logic [21:0] fx_raddr,
  input  logic [7:0]  fx_q,
  output logic        busy,
  output logic        err_opcode,
  output logic        err_timeout
);
  typedef enum logic [3:0] {IDLE, ADDR2, ADDR1, ADDR0, LEN, WDATA, RD_ISSUE, RD_WAIT, RD_SEND} state_t;
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYC - 1);
  state_t state_q, state_d;
  logic wr_op_q, wr_op_d;
  logic [5:0] dev_q, dev_d;
  logic [15:0] reg_q, reg_d;
  logic [8:0] cnt_q, cnt_d;
  logic [TO_W-1:0] to_q, to_d;
  logic rx_rdy_q, rx_rdy_d, busy_q, busy_d;
  logic [7:0] tx_data_q, tx_data_d, fx_data_q, fx_data_d;
  logic tx_vld_q, tx_vld_d, fx_wr_q, fx_wr_d, fx_rd_q, fx_rd_d;
  logic [21:0] fx_waddr_q, fx_waddr_d, fx_raddr_q, fx_raddr_d;
  logic err_op_q, err_op_d, err_to_q, err_to_d;
  logic acc, timed;
  always_comb begin
    acc = rx_vld & rx_rdy_q;
    timed = state_q inside {ADDR2, ADDR1, ADDR0, LEN, WDATA};
    state_d = state_q;
    wr_op_d = wr_op_q;
    dev_d = dev_q;
    reg_d = reg_q;
    cnt_d = cnt_q;
    to_d = '0;
    tx_data_d = tx_data_q;
    tx_vld_d = tx_vld_q;
    fx_waddr_d = fx_waddr_q;
    fx_wr_d = 1'b0;
    fx_data_d = fx_data_q;
    err_op_d = 1'b0;
    err_to_d = 1'b0;
    case (state_q)
      IDLE: if (acc) begin
        if (rx_data == 8'h57 || rx_data == 8'h52) begin
          wr_op_d = rx_data == 8'h57;
          state_d = ADDR2;
        end else err_op_d = 1'b1;
      end
      ADDR2: if (acc) begin
        dev_d = rx_data[5:0];
        state_d = ADDR1;
      end
      ADDR1: if (acc) begin
        reg_d[15:8] = rx_data;
        state_d = ADDR0;
      end
      ADDR0: if (acc) begin
        reg_d[7:0] = rx_data;
        state_d = LEN;
      end
      LEN: if (acc) begin
        cnt_d = {rx_data == 8'd0, rx_data};
        state_d = wr_op_q ? WDATA : RD_ISSUE;
      end
      WDATA: if (acc) begin
        fx_wr_d = 1'b1;
        fx_data_d = rx_data;
        fx_waddr_d = {dev_q, reg_q};
        reg_d = reg_q + 16'd1;
        cnt_d = cnt_q - 9'd1;
        state_d = cnt_q == 9'd1 ? IDLE : WDATA;
      end
      RD_ISSUE: state_d = RD_WAIT;
      RD_WAIT: begin
        tx_data_d = fx_q;
        tx_vld_d = 1'b1;
        state_d = RD_SEND;
      end
      RD_SEND: if (tx_rdy) begin
        tx_vld_d = 1'b0;
        cnt_d = cnt_q - 9'd1;
        reg_d = cnt_q == 9'd1 ? reg_q : reg_q + 16'd1;
        state_d = cnt_q == 9'd1 ? IDLE : RD_ISSUE;
      end
      default: state_d = IDLE;
    endcase
    // an accepted byte always wins over the timeout on the same edge
    if (timed && !acc) begin
      if (to_q == TO_MAX) begin
        state_d = IDLE;
        err_to_d = 1'b1;
      end else to_d = to_q + 1'b1;
    end
    fx_rd_d = state_d == RD_ISSUE;
    fx_raddr_d = state_d == RD_ISSUE ? {dev_d, reg_d} : fx_raddr_q;
    rx_rdy_d = state_d inside {IDLE, ADDR2, ADDR1, ADDR0, LEN, WDATA};
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wr_op_q <= 1'b0;
      dev_q <= '0;
      reg_q <= '0;
      cnt_q <= '0;
      to_q <= '0;
      rx_rdy_q <= 1'b0;
      busy_q <= 1'b0;
      tx_data_q <= '0;
      tx_vld_q <= 1'b0;
      fx_waddr_q <= '0;
      fx_wr_q <= 1'b0;
      fx_data_q <= '0;
      fx_rd_q <= 1'b0;
      fx_raddr_q <= '0;
      err_op_q <= 1'b0;
      err_to_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_op_q <= wr_op_d;
      dev_q <= dev_d;
      reg_q <= reg_d;
      cnt_q <= cnt_d;
      to_q <= to_d;
      rx_rdy_q <= rx_rdy_d;
      busy_q <= busy_d;
      tx_data_q <= tx_data_d;
      tx_vld_q <= tx_vld_d;
      fx_waddr_q <= fx_waddr_d;
      fx_wr_q <= fx_wr_d;
      fx_data_q <= fx_data_d;
      fx_rd_q <= fx_rd_d;
      fx_raddr_q <= fx_raddr_d;
      err_op_q <= err_op_d;
      err_to_q <= err_to_d;
    end
  end
  assign rx_rdy = rx_rdy_q;
  assign busy = busy_q;
  assign tx_data = tx_data_q;
  assign tx_vld = tx_vld_q;
  assign fx_waddr = fx_waddr_q;
  assign fx_wr = fx_wr_q;
  assign fx_data = fx_data_q;
  assign fx_rd = fx_rd_q;
  assign fx_raddr = fx_raddr_q;
  assign err_opcode = err_op_q;
  assign err_timeout = err_to_q;
endmodule

// File: tb/tb_fx_bus_master.sv
// tb_fx_bus_master: random command stream against a command-level model, checked by an event scoreboard
module tb_fx_bus_master;
  localparam int TO = 16;
  localparam int KW = 0, KR = 1, KT = 2, KEO = 3, KET = 4;
  logic clk_sys = 0, rst_n = 0;
  logic [7:0] rx_data = 0, tx_data, fx_data, fx_q = 0;
  logic rx_vld = 0, rx_rdy, tx_vld, tx_rdy = 0;
  logic [21:0] fx_waddr, fx_raddr;
  logic fx_wr, fx_rd, busy, err_opcode, err_timeout;
  int checks = 0, fails = 0;
  bit stall = 0;
  typedef struct {int k; logic [21:0] a; logic [7:0] d;} ev_t;
  ev_t q[$];
  logic hold = 0;
  logic [7:0] hold_d = 0;

  always #5 clk_sys = ~clk_sys;

  fx_bus_master #(.TIMEOUT_CYC(TO), .TO_W(5)) dut (
    .clk_sys(clk_sys), .rst_n(rst_n), .rx_data(rx_data), .rx_vld(rx_vld), .rx_rdy(rx_rdy),
    .tx_data(tx_data), .tx_vld(tx_vld), .tx_rdy(tx_rdy), .fx_waddr(fx_waddr), .fx_wr(fx_wr),
    .fx_data(fx_data), .fx_rd(fx_rd), .fx_raddr(fx_raddr), .fx_q(fx_q), .busy(busy),
    .err_opcode(err_opcode), .err_timeout(err_timeout));

  function automatic logic [7:0] slave(logic [21:0] a);
    if (a == 22'h050040) return 8'h30;
    if (a == 22'h050041) return 8'h00;
    return (a[7:0] * 8'd7) ^ a[15:8] ^ {2'b00, a[21:16]} ^ 8'hA5;
  endfunction

  function automatic string nm(int k);
    case (k)
      KW: return "fx_wr";
      KR: return "fx_rd";
      KT: return "tx_byte";
      KEO: return "err_opcode";
      default: return "err_timeout";
    endcase
  endfunction

  function automatic void push(int k, logic [21:0] a, logic [7:0] d);
    ev_t e;
    e.k = k; e.a = a; e.d = d;
    q.push_back(e);
  endfunction

  function automatic void chk(int k, logic [21:0] a, logic [7:0] d);
    ev_t e;
    checks++;
    if (q.size() == 0) begin
      fails++;
      $display("FAIL unexpected_%s: got addr=%h data=%h, required no event", nm(k), a, d);
    end else begin
      e = q.pop_front();
      if (e.k != k || e.a != a || e.d != d) begin
        fails++;
        $display("FAIL event_%s: got %s addr=%h data=%h, required %s addr=%h data=%h",
                 nm(k), nm(k), a, d, nm(e.k), e.a, e.d);
      end
    end
  endfunction

  function automatic logic any_out();
    return |{rx_rdy, tx_vld, tx_data, fx_wr, fx_rd, fx_waddr, fx_raddr, fx_data, busy, err_opcode, err_timeout};
  endfunction

  function automatic int gp(int g);
    return g < 0 ? int'($urandom_range(0, 3)) : g;
  endfunction

  // slave read data appears the cycle after fx_rd; an idle slave drives 0
  always @(posedge clk_sys) fx_q <= fx_rd ? slave(fx_raddr) : 8'h00;

  always @(posedge clk_sys) begin
    #1;
    tx_rdy = !stall && ($urandom_range(0, 3) != 0);
  end

  always @(negedge clk_sys) begin
    if (!rst_n) hold = 0;
    else begin
      if (hold) begin
        checks++;
        if (!tx_vld || tx_data != hold_d) begin
          fails++;
          $display("FAIL tx_hold: got vld=%b data=%h, required vld=1 data=%h", tx_vld, tx_data, hold_d);
        end
      end
      if (fx_wr && fx_rd) begin
        checks++; fails++;
        $display("FAIL wr_rd_overlap: got fx_wr=1 fx_rd=1, required not both");
      end
      if (fx_wr) chk(KW, fx_waddr, fx_data);
      if (fx_rd) chk(KR, fx_raddr, 8'h00);
      if (tx_vld && tx_rdy) chk(KT, 22'h0, tx_data);
      if (err_opcode) chk(KEO, 22'h0, 8'h00);
      if (err_timeout) chk(KET, 22'h0, 8'h00);
      hold = tx_vld && !tx_rdy;
      hold_d = tx_data;
    end
  end

  task automatic send(logic [7:0] b, int gap);
    int n = 0;
    rx_data = b;
    rx_vld = 1;
    while (!rx_rdy && n < 3000) begin
      @(negedge clk_sys);
      n++;
    end
    if (!rx_rdy) begin
      checks++; fails++;
      $display("FAIL rx_accept: got rx_rdy=0 after %0d cycles, required 1", n);
      rx_vld = 0;
      return;
    end
    @(negedge clk_sys);
    rx_vld = 0;
    repeat (gap) @(negedge clk_sys);
  endtask

  task automatic check_idle(string what);
    checks++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL %s: got busy=%b, required 0", what, busy);
    end
  endtask

  task automatic cmd_wr(logic [5:0] dev, logic [15:0] ra, int len, int g, int d0);
    logic [7:0] d[$];
    for (int i = 0; i < len; i++) begin
      d.push_back((i == 0 && d0 >= 0) ? 8'(d0) : 8'($urandom));
      push(KW, {dev, 16'(ra + i)}, d[i]);
    end
    send(8'h57, gp(g));
    send({2'($urandom), dev}, gp(g));
    send(ra[15:8], gp(g));
    send(ra[7:0], gp(g));
    send(8'(len), gp(g));
    for (int i = 0; i < len; i++) send(d[i], gp(g));
  endtask

  task automatic cmd_rd(logic [5:0] dev, logic [15:0] ra, int len, int g);
    for (int i = 0; i < len; i++) begin
      push(KR, {dev, 16'(ra + i)}, 8'h00);
      push(KT, 22'h0, slave({dev, 16'(ra + i)}));
    end
    send(8'h52, gp(g));
    send({2'($urandom), dev}, gp(g));
    send(ra[15:8], gp(g));
    send(ra[7:0], gp(g));
    send(8'(len), gp(g));
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 5000) begin
      @(negedge clk_sys);
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending events, required 0", q.size());
    end
  endtask

  initial begin
    logic [7:0] b, d0, d1;
    int r;
    repeat (3) @(negedge clk_sys);
    checks++;
    if (any_out()) begin
      fails++;
      $display("FAIL reset_outputs: got nonzero output, required all 0");
    end
    rst_n = 1;
    repeat (2) @(negedge clk_sys);
    checks++;
    if (rx_rdy !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL post_reset: got rx_rdy=%b busy=%b, required 1 0", rx_rdy, busy);
    end
    cmd_wr(6'h05, 16'h0040, 1, 0, 8'hAA);
    check_idle("busy_after_write");
    cmd_rd(6'h05, 16'h0040, 2, 0);
    cmd_wr(6'h03, 16'hFFFE, 3, -1, -1);
    cmd_wr(6'($urandom), 16'($urandom), 256, 0, -1);
    push(KEO, 22'h0, 8'h00);
    send(8'h13, 0);
    cmd_wr(6'h01, 16'h0080, 1, 0, 8'h55);
    // mid-command stall of exactly TO cycles: the next byte must land in IDLE
    push(KET, 22'h0, 8'h00);
    send(8'h57, 0);
    send(8'h01, 0);
    send(8'h00, TO);
    check_idle("busy_after_timeout");
    cmd_wr(6'h01, 16'h0200, 2, -1, -1);
    cmd_wr(6'h02, 16'h1234, 2, TO - 1, -1);
    d0 = 8'($urandom);
    d1 = 8'($urandom);
    push(KW, 22'h021234, d0);
    push(KW, 22'h021235, d1);
    push(KET, 22'h0, 8'h00);
    send(8'h57, 0); send(8'h02, 0); send(8'h12, 0); send(8'h34, 0); send(8'h03, 0);
    send(d0, 1);
    send(d1, TO);
    check_idle("busy_after_wdata_timeout");
    for (int i = 0; i < 30; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        b = 8'($urandom);
        if (b == 8'h57 || b == 8'h52) b = 8'h00;
        push(KEO, 22'h0, 8'h00);
        send(b, gp(-1));
      end else if (r < 5)
        cmd_wr(6'($urandom), ($urandom_range(0, 3) == 0) ? 16'hFFFD : 16'($urandom), $urandom_range(1, 6), -1, -1);
      else
        cmd_rd(6'($urandom), ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom), $urandom_range(1, 6), -1);
    end
    drain();
    stall = 1;
    cmd_rd(6'h07, 16'h0100, 4, 0);
    r = 0;
    while (!tx_vld && r < 100) begin
      @(negedge clk_sys);
      r++;
    end
    checks++;
    if (!tx_vld) begin
      fails++;
      $display("FAIL read_tx_vld: got tx_vld=0, required 1");
    end
    repeat (10) begin
      @(negedge clk_sys);
      checks++;
      if (fx_rd) begin
        fails++;
        $display("FAIL stall_no_rd: got fx_rd=1, required 0");
      end
    end
    #2 rst_n = 0;
    #1;
    checks++;
    if (any_out()) begin
      fails++;
      $display("FAIL async_reset: got nonzero output, required all 0");
    end
    q.delete();
    stall = 0;
    repeat (3) @(negedge clk_sys);
    rst_n = 1;
    repeat (20) @(negedge clk_sys);
    check_idle("busy_after_reset");
    cmd_rd(6'h07, 16'h0100, 2, -1);
    cmd_wr(6'h07, 16'hFFFF, 2, -1, -1);
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
